div_unit: RTL

Multi-cycle 32-bit integer divider that services divide requests issued by the execute stage of the MIPS pipeline. It accepts operands and a start request, and holds the requester stalled while it iterates. It then returns a 64-bit {remainder, quotient} word formatted for the HI/LO register path. It sits beside the ALU in the execute stage and is the responder side of the ALU's divide-start / divide-stall handshake.

---
 rtl/div_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for the execute stage.
// Returns {remainder, quotient} for the HI/LO path and stalls the requester while it iterates.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        annul,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        stall,
    output logic        ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DZERO, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [31:0] dvd, dvs, prem;
    logic        qneg, rneg;

    logic [31:0] mag_a, mag_b;
    logic [32:0] shifted, diff;
    logic        qbit;
    logic [31:0] rem_step, quo_step, quo_fix, rem_fix;

    assign mag_a = (signed_div && opa[31]) ? -opa : opa;
    assign mag_b = (signed_div && opb[31]) ? -opb : opb;

    // dvd shifts dividend bits out the top while quotient bits enter at the bottom
    assign shifted  = {prem, dvd[31]};
    assign diff     = shifted - {1'b0, dvs};
    assign qbit     = ~diff[32];
    assign rem_step = qbit ? diff[31:0] : shifted[31:0];
    assign quo_step = {dvd[30:0], qbit};
    assign quo_fix  = qneg ? -quo_step : quo_step;
    assign rem_fix  = rneg ? -rem_step : rem_step;

    assign stall = start & ~annul & (state != DONE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (annul) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = (opb == 32'd0) ? DZERO : BUSY;
                BUSY:    if (count == 5'd31) state_next = DONE;
                DZERO:   state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= 5'd0;
            dvd    <= 32'd0;
            dvs    <= 32'd0;
            prem   <= 32'd0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            ready  <= 1'b0;
            result <= 64'd0;
        end else begin
            ready <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start && !annul) begin
                        // A zero divisor keeps the raw dividend for the DZERO result
                        dvd   <= (opb == 32'd0) ? opa : mag_a;
                        dvs   <= mag_b;
                        prem  <= 32'd0;
                        count <= 5'd0;
                        qneg  <= signed_div & (opa[31] ^ opb[31]);
                        rneg  <= signed_div & opa[31];
                    end
                end
                BUSY: begin
                    if (!annul) begin
                        prem  <= rem_step;
                        dvd   <= quo_step;
                        count <= count + 5'd1;
                        if (count == 5'd31) result <= {rem_fix, quo_fix};
                    end
                end
                DZERO: begin
                    if (!annul) result <= {dvd, 32'hFFFF_FFFF};
                end
                default: ;
            endcase
        end
    end

endmodule
